cla_4bit: RTL and testbench

4-bit carry-lookahead adder with a registered output stage. Computes A+B+Cin through explicit generate/propagate lookahead logic, with no ripple chain. Also reports group propagate/generate for cascading into a higher-level lookahead unit, plus a signed-overflow flag. Used as a leaf arithmetic cell inside wider datapaths.

---
 rtl/cla_4bit.sv | 107 ++++++++++
 tb/tb_cla_4bit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cla_4bit.sv
// ============================================================================
// Module   : cla_4bit
// Brief    : 4-bit carry-lookahead adder with registered outputs and group
//            propagate/generate. Optional input register stage: CLA_INPUT_REG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       Pg,
  output logic       Gg,
  output logic       Ovf
);

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_c;

`ifdef CLA_INPUT_REG_EN
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       cin_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= 4'b0000;
      b_q   <= 4'b0000;
      cin_q <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= Cin;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
  assign op_c = cin_q;
`else
  assign op_a = A;
  assign op_b = B;
  assign op_c = Cin;
`endif

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign g[i] = op_a[i] & op_b[i];
    assign p[i] = op_a[i] ^ op_b[i];
  end

  // Every carry is a flat sum-of-products of g/p/Cin; none depends on another carry.
  assign c[0] = op_c;
  assign c[1] = g[0] | (p[0] & op_c);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & op_c);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & op_c);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & op_c);

  logic [3:0] sum_d, sum_q;
  logic       cout_d, cout_q;
  logic       pg_d, pg_q;
  logic       gg_d, gg_q;
  logic       ovf_d, ovf_q;

  assign sum_d  = p ^ c[3:0];
  assign cout_d = c[4];
  assign pg_d   = &p;
  assign gg_d   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
  assign ovf_d  = c[4] ^ c[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= 4'b0000;
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Pg   = pg_q;
  assign Gg   = gg_q;
  assign Ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_4bit.sv
// ============================================================================
// Module   : tb_cla_4bit
// Brief    : Self-checking bench for cla_4bit: directed vectors, exhaustive
//            sweep with mid-sweep reset, random vectors vs arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cla_4bit;

`ifdef CLA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       Pg;
  logic       Gg;
  logic       Ovf;

  int n_checks;
  int n_pass;

  bit         hist_rst[$];
  logic [7:0] hist_val[$];

  cla_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Sum   (Sum),
    .Cout  (Cout),
    .Pg    (Pg),
    .Gg    (Gg),
    .Ovf   (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed result layout: {Sum[3:0], Cout, Pg, Gg, Ovf}
  function automatic logic [7:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
    int us, sv;
    logic [7:0] r;
    us = int'(a) + int'(b) + int'(cin);
    sv = int'($signed(a)) + int'($signed(b)) + int'(cin);
    r[7:4] = us[3:0];
    r[3]   = (us > 15);
    r[2]   = ((a ^ b) == 4'hF);
    r[1]   = ((int'(a) + int'(b)) > 15);
    r[0]   = (sv > 7) || (sv < -8);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (Sum,Cout,Pg,Gg,Ovf)", tag, got, exp);
  endtask

  function automatic logic [7:0] observed();
    return {Sum, Cout, Pg, Gg, Ovf};
  endfunction

  // Outputs after edge k are zero if reset was seen on any of the last LAT
  // edges, otherwise the sum of inputs sampled LAT-1 edges earlier.
  function automatic logic [7:0] expected_now();
    int n;
    n = hist_rst.size();
    for (int i = n - LAT; i < n; i++)
      if (hist_rst[i]) return 8'h00;
    return hist_val[n - LAT];
  endfunction

  task automatic step(input bit rst, input logic [3:0] a, input logic [3:0] b,
                      input logic cin);
    rst_n = ~rst;
    A     = a;
    B     = b;
    Cin   = cin;
    @(posedge clk);
    #1;
    hist_rst.push_back(rst);
    hist_val.push_back(ref_model(a, b, cin));
  endtask

  task automatic directed(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic [7:0] exp);
    for (int k = 0; k < LAT; k++) step(1'b0, a, b, cin);
    check(tag, observed(), exp);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    A = 4'h0;
    B = 4'h0;
    Cin = 1'b0;

    step(1'b1, 4'hF, 4'hF, 1'b1);
    step(1'b1, 4'hF, 4'hF, 1'b1);
    check("reset", observed(), 8'b0000_0000);

    directed("release_f_f_1", 4'hF, 4'hF, 1'b1, 8'b1111_1010);
    directed("zero",          4'h0, 4'h0, 1'b0, 8'b0000_0000);
    directed("5p3_c0",        4'h5, 4'h3, 1'b0, 8'b1000_0001);
    directed("5p3_c1",        4'h5, 4'h3, 1'b1, 8'b1001_0001);
    directed("wrap_f_1",      4'hF, 4'h1, 1'b0, 8'b0000_1010);
    directed("prop_a_5_1",    4'hA, 4'h5, 1'b1, 8'b0000_1100);

    for (int i = 0; i < 512; i++) begin
      if (i == 200) begin
        step(1'b1, 4'hF, 4'hF, 1'b1);
        check("sweep_reset", observed(), 8'h00);
      end
      step(1'b0, i[3:0], i[7:4], i[8]);
      check($sformatf("sweep_%0d", i), observed(), expected_now());
    end
    for (int k = 0; k < LAT; k++) begin
      step(1'b0, 4'h0, 4'h0, 1'b0);
      check("sweep_tail", observed(), expected_now());
    end

    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 31) == 0), ra, rb, rc);
      check($sformatf("rand_%0d", i), observed(), expected_now());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
